// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and helpers shared by the UART Tx and Rx sides
package uart_pkg;

  typedef enum logic [1:0] {
    sIDLE  = 2'b00,
    sSTART = 2'b01,
    sDATA  = 2'b10,
    sSTOP  = 2'b11
  } uartState_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divide-by-C_DIV bit-period counter with restart and end-of-period tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int C_DIV = 868
) (
  input  logic clk,
  input  logic rstb,
  input  logic restart,
  output logic tick
);

  localparam int CW = (clog2(C_DIV) < 1) ? 1 : clog2(C_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(C_DIV - 1));

  // count 0..C_DIV-1 repeatedly; restart aligns period start with the cycle after it
  always_ff @(posedge clk) begin
    if (!rstb || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 1 start bit, LSB-first data, 1 stop bit, no parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int C_CLK_FREQ        = 100000000,
  parameter int C_UART_RATE       = 115200,
  parameter int C_UART_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         send,
  input  logic [C_UART_DATA_WIDTH-1:0] data,
  output logic                         busy,
  output logic                         err,
  output logic                         tx
);

  localparam int N  = C_CLK_FREQ / C_UART_RATE;
  localparam int IW = (clog2(C_UART_DATA_WIDTH) < 1) ? 1 : clog2(C_UART_DATA_WIDTH);

  if (N < 4) begin : gBadDivisor
    $error("uart_tx: clock/baud divisor must be at least 4");
  end

  uartState_t                   state, nState;
  logic [C_UART_DATA_WIDTH-1:0] shift, nShift;
  logic [IW-1:0]                idx, nIdx;
  logic                         nErr, nTx, nBusy, restart, tick;

  uart_baud_gen #(.C_DIV(N)) uBaud (
    .clk(clk),
    .rstb(rstb),
    .restart(restart),
    .tick(tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rstb) state <= sIDLE;
    else state <= nState;
  end

  // next state, datapath updates and the values the output flops take next
  always_comb begin
    nState  = state;
    nShift  = shift;
    nIdx    = idx;
    nErr    = err;
    restart = 1'b0;
    case (state)
      sIDLE: if (send) begin
        nShift  = data;
        nErr    = 1'b0;
        nState  = sSTART;
        restart = 1'b1;
      end
      sSTART: if (tick) begin
        nState = sDATA;
        nIdx   = '0;
      end
      sDATA: if (tick) begin
        nShift = shift >> 1;
        nIdx   = idx + IW'(1);
        nState = (idx == IW'(C_UART_DATA_WIDTH - 1)) ? sSTOP : sDATA;
      end
      default: if (tick) nState = sIDLE;
    endcase
    if (state != sIDLE && send) nErr = 1'b1;
    nTx   = (nState == sSTART) ? 1'b0 : (nState == sDATA) ? nShift[0] : 1'b1;
    nBusy = (nState != sIDLE);
  end

  // registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!rstb) begin
      shift <= '0;
      idx   <= '0;
      err   <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      shift <= nShift;
      idx   <= nIdx;
      err   <= nErr;
      tx    <= nTx;
      busy  <= nBusy;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench against a frame-timeline reference model
module tb_uart_tx;

  localparam int N     = 100;
  localparam int W     = 8;
  localparam int FRAME = (W + 2) * N;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         send = 1'b0;
  logic [W-1:0] data = '0;
  logic         busy, err, tx;

  int           nCompared = 0;
  int           nMismatched = 0;

  int           rem = 0;
  logic [W-1:0] word = '0;
  logic         mErr = 1'b0;

  uart_tx #(
    .C_CLK_FREQ(100000000),
    .C_UART_RATE(1000000),
    .C_UART_DATA_WIDTH(W)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .send(send),
    .data(data),
    .busy(busy),
    .err(err),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic expTx();
    int b;
    if (rem == 0) return 1'b1;
    b = (FRAME - rem) / N;
    if (b == 0) return 1'b0;
    if (b <= W) return word[b-1];
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic s, input logic [W-1:0] d);
    rstb = r;
    send = s;
    data = d;
    @(posedge clk);
    if (!r) begin
      rem  = 0;
      mErr = 1'b0;
    end else if (rem > 0) begin
      if (s) mErr = 1'b1;
      rem--;
    end else if (s) begin
      rem  = FRAME;
      word = d;
      mErr = 1'b0;
    end
    #1;
    checkVal("tx", 32'(tx), 32'(expTx()));
    checkVal("busy", 32'(busy), 32'(rem > 0));
    checkVal("err", 32'(err), 32'(mErr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'($urandom));
    idle(3);
    step(1'b1, 1'b1, 8'hA5);
    idle(FRAME + 5);
    step(1'b1, 1'b1, 8'hA5);
    idle(299);
    step(1'b1, 1'b1, 8'h3C);
    idle(FRAME);
    checkVal("err_sticky", 32'(err), 32'(1));
    step(1'b1, 1'b1, W'($urandom));
    checkVal("err_cleared", 32'(err), 32'(0));
    idle(FRAME + 5);
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < FRAME + 1; i++) step(1'b1, 1'b1, 8'hFF);
    idle(FRAME + 5);
    step(1'b1, 1'b1, W'($urandom));
    idle(449);
    step(1'b0, 1'b1, W'($urandom));
    checkVal("rst_mid_busy", 32'(busy), 32'(0));
    step(1'b1, 1'b1, 8'h81);
    idle(FRAME + 5);
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, FRAME + 300);
      for (int i = 0; i < len; i++)
        step(($urandom_range(0, 999) != 0), ($urandom_range(0, 199) == 0), W'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(FRAME + 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
